// File: rtl/spi_txn_arbiter_pkg.sv
// Shared types and defaults for the SPI transaction arbiter.
package spi_txn_arbiter_pkg;

  // Transaction FSM states
  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_ARB        = 3'd1,
    ST_LOAD       = 3'd2,
    ST_WAIT_START = 3'd3,
    ST_WAIT_END   = 3'd4,
    ST_GAP        = 3'd5
  } state_t;

  localparam int DEF_GAP_CYCLES = 2;
  localparam int DEF_TMO_CYCLES = 64;

  typedef logic [7:0] byte_t;

  // Round-robin successor of a requester index, wrapping at n
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/spi_txn_arbiter_if.sv
// Byte-level link between the arbiter and the shared spi_master.
interface spi_txn_arbiter_if;
  import spi_txn_arbiter_pkg::*;

  logic  m_en;
  byte_t m_data_in;
  byte_t m_data_out;
  logic  m_cs;

  // Arbiter side: starts bytes and reads back the received data
  modport master (
    output m_en,
    output m_data_in,
    input  m_data_out,
    input  m_cs
  );

  // spi_master side
  modport slave (
    input  m_en,
    input  m_data_in,
    output m_data_out,
    output m_cs
  );
endinterface

// File: rtl/spi_txn_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IDXW = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDXW-1:0] gnt_idx,
  output logic            found
);

  logic [IDXW-1:0] cand_s;

  // Scan requesters starting at ptr; the first hit wins
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand_s  = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand_s = IDXW'((int'(ptr) + i) % NREQ);
      if (!found && req[cand_s]) begin
        gnt[cand_s] = 1'b1;
        gnt_idx     = cand_s;
        found       = 1'b1;
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/spi_txn_arbiter.sv
// Shares one spi_master among NREQ requesters; each grant covers a whole
// multi-byte transaction, with a fixed idle gap and a per-edge timeout.
module spi_txn_arbiter
  import spi_txn_arbiter_pkg::*;
#(
  parameter int NREQ       = 2,
  parameter int LENW       = 4,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES,
  parameter int TMO_CYCLES = DEF_TMO_CYCLES
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*LENW-1:0] req_len,
  input  logic [NREQ*8-1:0]    tx_data,
  output logic [NREQ-1:0]      tx_ack,
  output byte_t                rx_data,
  output logic [NREQ-1:0]      rx_valid,
  output logic [NREQ-1:0]      done,
  output logic [NREQ-1:0]      grant,
  output logic                 busy,
  output logic                 timeout_err,
  spi_txn_arbiter_if.master    mbus
);

  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TMOW = $clog2(TMO_CYCLES + 1);
  localparam int GAPW = $clog2(GAP_CYCLES + 1);

  state_t          state_r;
  logic [IDXW-1:0] owner_r;
  logic [IDXW-1:0] ptr_r;
  logic [LENW-1:0] remain_r;
  logic [TMOW-1:0] tmo_cnt_r;
  logic [GAPW-1:0] gap_cnt_r;
  logic [NREQ-1:0] grant_r;
  logic [NREQ-1:0] tx_ack_r;
  logic [NREQ-1:0] rx_valid_r;
  logic [NREQ-1:0] done_r;
  logic            busy_r;
  logic            timeout_err_r;
  byte_t           rx_data_r;
  logic            m_en_r;
  byte_t           m_data_in_r;

  logic [NREQ-1:0] gnt_s;
  logic [IDXW-1:0] gnt_idx_s;
  logic            found_s;
  logic [LENW-1:0] len_s;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDXW (IDXW)
  ) u_rr (
    .req     (req),
    .ptr     (ptr_r),
    .gnt     (gnt_s),
    .gnt_idx (gnt_idx_s),
    .found   (found_s)
  );

  assign len_s = req_len[int'(gnt_idx_s)*LENW +: LENW];

  // Transaction FSM with all counters and registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r       <= ST_IDLE;
      owner_r       <= '0;
      ptr_r         <= '0;
      remain_r      <= '0;
      tmo_cnt_r     <= '0;
      gap_cnt_r     <= '0;
      grant_r       <= '0;
      tx_ack_r      <= '0;
      rx_valid_r    <= '0;
      done_r        <= '0;
      busy_r        <= 1'b0;
      timeout_err_r <= 1'b0;
      rx_data_r     <= 8'h00;
      m_en_r        <= 1'b0;
      m_data_in_r   <= 8'h00;
    end else begin
      // Pulse outputs last a single cycle unless re-asserted below
      tx_ack_r      <= '0;
      rx_valid_r    <= '0;
      done_r        <= '0;
      timeout_err_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (|req) state_r <= ST_ARB;
          else      state_r <= ST_IDLE;
        end
        ST_ARB: begin
          if (found_s) begin
            grant_r <= gnt_s;
            owner_r <= gnt_idx_s;
            busy_r  <= 1'b1;
            ptr_r   <= IDXW'(rr_next(int'(gnt_idx_s), NREQ));
            if (len_s == '0) begin
              // Empty transaction completes without touching the master
              done_r    <= gnt_s;
              gap_cnt_r <= '0;
              state_r   <= ST_GAP;
            end else begin
              remain_r <= len_s;
              state_r  <= ST_LOAD;
            end
          end else begin
            // Request vanished between IDLE and ARB
            state_r <= ST_IDLE;
          end
        end
        ST_LOAD: begin
          m_data_in_r <= tx_data[int'(owner_r)*8 +: 8];
          tx_ack_r    <= grant_r;
          m_en_r      <= 1'b1;
          tmo_cnt_r   <= '0;
          state_r     <= ST_WAIT_START;
        end
        ST_WAIT_START: begin
          if (!mbus.m_cs) begin
            m_en_r    <= 1'b0;
            tmo_cnt_r <= '0;
            state_r   <= ST_WAIT_END;
          end else if (tmo_cnt_r == TMOW'(TMO_CYCLES - 1)) begin
            m_en_r        <= 1'b0;
            timeout_err_r <= 1'b1;
            done_r        <= grant_r;
            gap_cnt_r     <= '0;
            state_r       <= ST_GAP;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + 1'b1;
          end
        end
        ST_WAIT_END: begin
          if (mbus.m_cs) begin
            rx_data_r  <= mbus.m_data_out;
            rx_valid_r <= grant_r;
            remain_r   <= remain_r - 1'b1;
            if (remain_r == LENW'(1)) begin
              done_r    <= grant_r;
              gap_cnt_r <= '0;
              state_r   <= ST_GAP;
            end else begin
              state_r <= ST_LOAD;
            end
          end else if (tmo_cnt_r == TMOW'(TMO_CYCLES - 1)) begin
            // Aborted byte yields no rx_valid
            m_en_r        <= 1'b0;
            timeout_err_r <= 1'b1;
            done_r        <= grant_r;
            gap_cnt_r     <= '0;
            state_r       <= ST_GAP;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + 1'b1;
          end
        end
        ST_GAP: begin
          if (gap_cnt_r == GAPW'(GAP_CYCLES - 1)) begin
            grant_r <= '0;
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end else begin
            gap_cnt_r <= gap_cnt_r + 1'b1;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  assign tx_ack         = tx_ack_r;
  assign rx_data        = rx_data_r;
  assign rx_valid       = rx_valid_r;
  assign done           = done_r;
  assign grant          = grant_r;
  assign busy           = busy_r;
  assign timeout_err    = timeout_err_r;
  assign mbus.m_en      = m_en_r;
  assign mbus.m_data_in = m_data_in_r;

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Directed scoreboard bench for spi_txn_arbiter with a simple spi_master model.
module tb_spi_txn_arbiter;

  localparam int NREQ = 2;
  localparam int LENW = 4;
  localparam int GAP  = 2;
  localparam int TMO  = 64;

  logic               clk = 1'b0;
  logic               rst;
  logic [NREQ-1:0]    req;
  logic [NREQ*LENW-1:0] req_len;
  logic [NREQ*8-1:0]  tx_data;
  logic [NREQ-1:0]    tx_ack, rx_valid, done, grant;
  logic [7:0]         rx_data;
  logic               busy, timeout_err;

  spi_txn_arbiter_if mif();

  spi_txn_arbiter #(
    .NREQ(NREQ), .LENW(LENW), .GAP_CYCLES(GAP), .TMO_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_len(req_len), .tx_data(tx_data),
    .tx_ack(tx_ack), .rx_data(rx_data), .rx_valid(rx_valid), .done(done),
    .grant(grant), .busy(busy), .timeout_err(timeout_err), .mbus(mif)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard queues and stimulus sources
  logic [7:0] src0_q[$];
  logic [7:0] src1_q[$];
  logic [7:0] resp_q[$];
  logic [7:0] exp_mosi_q[$];
  logic [7:0] exp_rx_dat_q[$];
  int         exp_rx_idx_q[$];
  logic [1:0] grant_hist[$];
  int         gap_hist[$];

  // Observed event counters
  int tx_ack_cnt[2];
  int done_cnt[2];
  int to_cnt = 0;
  int rx_cnt = 0;
  int en_rise_cnt = 0;
  int en_rise_cyc = 0;
  int cyc = 0;
  int since_done = 0;
  logic       prev_en = 1'b0;
  logic [1:0] prev_grant = 2'b00;
  logic [1:0] exp_to_done = 2'b00;
  logic       slave_mute = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int idx, input int target, input int budget);
    int n = 0;
    while (done_cnt[idx] < target && n < budget) begin
      tick();
      n++;
    end
    check($sformatf("done%0d_wait", idx), 32'(done_cnt[idx] >= target), 32'd1);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin
      tick();
      n++;
    end
    check("busy_drop", 32'(busy), 32'd0);
  endtask

  // Requesters: present the head of each source queue, advance on tx_ack
  initial begin
    tx_data = '0;
    forever begin
      @(negedge clk);
      if (tx_ack[0] && src0_q.size() > 0) void'(src0_q.pop_front());
      if (tx_ack[1] && src1_q.size() > 0) void'(src1_q.pop_front());
      tx_data[7:0]  = (src0_q.size() > 0) ? src0_q[0] : 8'h00;
      tx_data[15:8] = (src1_q.size() > 0) ? src1_q[0] : 8'h00;
    end
  end

  // spi_master model: cs low one cycle after en, high again three cycles later
  initial begin
    logic [7:0] e;
    mif.m_cs = 1'b1;
    mif.m_data_out = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (mif.m_en === 1'b1 && !slave_mute) begin
        if (exp_mosi_q.size() > 0) begin
          e = exp_mosi_q.pop_front();
          check("mosi_byte", 32'(mif.m_data_in), 32'(e));
        end else begin
          check("mosi_extra", 32'(exp_mosi_q.size()), 32'd1);
        end
        mif.m_cs = 1'b0;
        repeat (3) begin
          @(posedge clk);
          #1;
        end
        mif.m_data_out = (resp_q.size() > 0) ? resp_q.pop_front() : 8'h00;
        mif.m_cs = 1'b1;
      end
    end
  end

  // Output monitor: one-hot rules, rx scoreboard, event counting, timing capture
  initial begin
    int idx;
    logic [7:0] d;
    tx_ack_cnt = '{0, 0};
    done_cnt   = '{0, 0};
    forever begin
      @(negedge clk);
      cyc++;
      check("onehot_grant", 32'($onehot0(grant)), 32'd1);
      check("onehot_done", 32'($onehot0(done)), 32'd1);
      check("txack_owner", 32'(tx_ack & ~grant), 32'd0);
      check("rxv_owner", 32'(rx_valid & ~grant), 32'd0);
      if (mif.m_en && !prev_en) begin
        en_rise_cnt++;
        en_rise_cyc = cyc;
      end
      prev_en = mif.m_en;
      for (int i = 0; i < NREQ; i++) begin
        if (tx_ack[i]) tx_ack_cnt[i]++;
        if (done[i]) done_cnt[i]++;
      end
      if (rx_valid != 2'b00) begin
        rx_cnt++;
        if (exp_rx_idx_q.size() > 0) begin
          idx = exp_rx_idx_q.pop_front();
          d = exp_rx_dat_q.pop_front();
          check("rx_valid_idx", 32'(rx_valid), 32'd1 << idx);
          check("rx_data", 32'(rx_data), 32'(d));
        end else begin
          check("rx_extra", 32'(exp_rx_idx_q.size()), 32'd1);
        end
      end
      if (timeout_err) begin
        to_cnt++;
        check("to_latency", 32'(cyc - en_rise_cyc), 32'(TMO));
        check("to_done", 32'(done), 32'(exp_to_done));
        check("to_men", 32'(mif.m_en), 32'd0);
      end
      if (done != 2'b00) since_done = 0;
      else since_done++;
      if (grant != 2'b00 && prev_grant == 2'b00) begin
        grant_hist.push_back(grant);
        gap_hist.push_back(since_done);
      end
      prev_grant = grant;
    end
  end

  initial begin
    int k, n, d0, d1, en0, ta1;
    rst = 1'b0;
    req = '0;
    req_len = '0;
    repeat (3) tick();
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_men", 32'(mif.m_en), 32'd0);
    check("rst_mdata", 32'(mif.m_data_in), 32'd0);
    check("rst_rxdata", 32'(rx_data), 32'd0);
    check("rst_pulses", 32'({tx_ack, rx_valid, done, timeout_err}), 32'd0);
    rst = 1'b1;
    tick();

    // Single requester, three bytes
    src0_q.push_back(8'hA5); src0_q.push_back(8'h3C); src0_q.push_back(8'hFF);
    exp_mosi_q.push_back(8'hA5); exp_mosi_q.push_back(8'h3C); exp_mosi_q.push_back(8'hFF);
    resp_q.push_back(8'h11); resp_q.push_back(8'h22); resp_q.push_back(8'h33);
    exp_rx_idx_q.push_back(0); exp_rx_dat_q.push_back(8'h11);
    exp_rx_idx_q.push_back(0); exp_rx_dat_q.push_back(8'h22);
    exp_rx_idx_q.push_back(0); exp_rx_dat_q.push_back(8'h33);
    req_len[3:0] = 4'd3;
    req = 2'b01;
    tick();
    check("lat_grant_early", 32'(grant), 32'd0);
    tick();
    check("lat_grant", 32'(grant), 32'd1);
    check("lat_busy", 32'(busy), 32'd1);
    tick();
    check("lat_men", 32'(mif.m_en), 32'd1);
    wait_done(0, 1, 200);
    req = 2'b00;
    wait_idle(20);
    check("t1_txack", 32'(tx_ack_cnt[0]), 32'd3);
    check("t1_timeout", 32'(to_cnt), 32'd0);
    check("t1_rx_left", 32'(exp_rx_idx_q.size()), 32'd0);

    // Request dropped after first byte: transaction still completes
    src0_q.push_back(8'h5A); src0_q.push_back(8'hC3);
    exp_mosi_q.push_back(8'h5A); exp_mosi_q.push_back(8'hC3);
    resp_q.push_back(8'h44); resp_q.push_back(8'h55);
    exp_rx_idx_q.push_back(0); exp_rx_dat_q.push_back(8'h44);
    exp_rx_idx_q.push_back(0); exp_rx_dat_q.push_back(8'h55);
    req_len[3:0] = 4'd2;
    req = 2'b01;
    n = 0;
    while (tx_ack_cnt[0] < 4 && n < 100) begin tick(); n++; end
    req = 2'b00;
    wait_done(0, 2, 200);
    wait_idle(20);
    check("t6_txack", 32'(tx_ack_cnt[0]), 32'd5);
    check("t6_rx_left", 32'(exp_rx_idx_q.size()), 32'd0);

    // Contention, one byte each; pointer now favours requester 1
    grant_hist.delete();
    gap_hist.delete();
    src0_q.push_back(8'h10); src0_q.push_back(8'h12);
    src1_q.push_back(8'h20); src1_q.push_back(8'h22);
    exp_mosi_q.push_back(8'h20); exp_mosi_q.push_back(8'h10);
    exp_mosi_q.push_back(8'h22); exp_mosi_q.push_back(8'h12);
    resp_q.push_back(8'h91); resp_q.push_back(8'h92);
    resp_q.push_back(8'h93); resp_q.push_back(8'h94);
    exp_rx_idx_q.push_back(1); exp_rx_dat_q.push_back(8'h91);
    exp_rx_idx_q.push_back(0); exp_rx_dat_q.push_back(8'h92);
    exp_rx_idx_q.push_back(1); exp_rx_dat_q.push_back(8'h93);
    exp_rx_idx_q.push_back(0); exp_rx_dat_q.push_back(8'h94);
    req_len = {4'd1, 4'd1};
    req = 2'b11;
    wait_done(1, 2, 400);
    wait_done(0, 4, 200);
    req = 2'b00;
    wait_idle(20);
    check("t2_grants", 32'(grant_hist.size()), 32'd4);
    for (int i = 0; i < 4 && i < grant_hist.size(); i++)
      check($sformatf("t2_grant%0d", i), 32'(grant_hist[i]), (i % 2 == 0) ? 32'd2 : 32'd1);
    for (int i = 1; i < gap_hist.size(); i++)
      check($sformatf("t2_gap%0d", i), 32'(gap_hist[i]), 32'(GAP + 2));

    // Zero-length transaction on requester 1
    d1 = done_cnt[1];
    en0 = en_rise_cnt;
    ta1 = tx_ack_cnt[1];
    req_len[7:4] = 4'd0;
    req = 2'b10;
    tick();
    tick();
    check("t3_done", 32'(done), 32'd2);
    check("t3_grant", 32'(grant), 32'd2);
    req = 2'b00;
    wait_idle(20);
    check("t3_done_cnt", 32'(done_cnt[1]), 32'(d1 + 1));
    check("t3_no_men", 32'(en_rise_cnt), 32'(en0));
    check("t3_no_txack", 32'(tx_ack_cnt[1]), 32'(ta1));

    // Slave never answers: abort after the timeout
    slave_mute = 1'b1;
    exp_to_done = 2'b01;
    d0 = done_cnt[0];
    k = rx_cnt;
    src0_q.push_back(8'h77);
    req_len[3:0] = 4'd1;
    req = 2'b01;
    wait_done(0, d0 + 1, TMO + 40);
    req = 2'b00;
    wait_idle(20);
    check("t4_timeouts", 32'(to_cnt), 32'd1);
    check("t4_no_rx", 32'(rx_cnt), 32'(k));
    check("t4_men", 32'(mif.m_en), 32'd0);
    slave_mute = 1'b0;
    tick();

    // Reset in the middle of byte 2 of 4
    src0_q.push_back(8'hB1); src0_q.push_back(8'hB2);
    src0_q.push_back(8'hB3); src0_q.push_back(8'hB4);
    exp_mosi_q.push_back(8'hB1); exp_mosi_q.push_back(8'hB2);
    resp_q.push_back(8'hC1); resp_q.push_back(8'hC2);
    exp_rx_idx_q.push_back(0); exp_rx_dat_q.push_back(8'hC1);
    req_len[3:0] = 4'd4;
    req = 2'b01;
    k = 0;
    n = 0;
    while (k < 2 && n < 300) begin
      tick();
      n++;
      if (tx_ack[0]) k++;
    end
    check("t5_second_ack", 32'(k), 32'd2);
    rst = 1'b0;
    tick();
    check("t5_rst_men", 32'(mif.m_en), 32'd0);
    check("t5_rst_grant", 32'(grant), 32'd0);
    check("t5_rst_busy", 32'(busy), 32'd0);
    req = 2'b00;
    src0_q.delete();
    repeat (6) tick();
    rst = 1'b1;
    tick();

    // Pointer restarts at 0: requester 0 wins, then requester 1
    grant_hist.delete();
    d1 = done_cnt[1];
    req_len = {4'd0, 4'd0};
    req = 2'b11;
    n = 0;
    while (grant == 2'b00 && n < 20) begin tick(); n++; end
    check("t5_first_grant", 32'(grant), 32'd1);
    wait_done(1, d1 + 1, 40);
    req = 2'b00;
    wait_idle(20);
    check("t5_grant_cnt", 32'(grant_hist.size()), 32'd2);
    if (grant_hist.size() >= 2) check("t5_second_grant", 32'(grant_hist[1]), 32'd2);

    check("end_mosi_left", 32'(exp_mosi_q.size()), 32'd0);
    check("end_rx_left", 32'(exp_rx_idx_q.size()), 32'd0);
    check("end_timeouts", 32'(to_cnt), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
